membrane_debug_serializer: RTL and testbench

MEMBRANE_DEBUG_SERIALIZER -- requirements
Module: membrane_debug_serializer

---
 rtl/membrane_debug_serializer_pkg.sv | 29 ++
 rtl/membrane_debug_serializer_byte_mux.sv | 38 +++
 rtl/membrane_debug_serializer.sv | 159 +++++++++++++++
 tb/tb_membrane_debug_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/membrane_debug_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : membrane_debug_serializer_pkg
// Description : Shared FSM encoding, frame header and payload sizing helper.
//               The CHECKSUM state exists only with DEBUG_FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package membrane_debug_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HEADER   = 2'd1,
`ifdef DEBUG_FRAME_CHECKSUM_EN
        ST_PAYLOAD  = 2'd2,
        ST_CHECKSUM = 2'd3
`else
        ST_PAYLOAD  = 2'd2
`endif
    } state_t;

    localparam logic [7:0] c_frame_header = 8'hA5;

    // Potentials plus both spike vectors, rounded up to whole bytes.
    function automatic int calc_payload_bytes(input int n1, input int n2, input int pw);
        return ((n1 + n2) * pw + n1 + n2 + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/membrane_debug_serializer_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : debug_byte_mux
// Description : Selects byte i_index of the captured payload register.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_byte_mux
    import membrane_debug_serializer_pkg::*;
#(
    parameter int NB = 9,
    parameter int IW = 4
) (
    input  logic [NB*8-1:0] i_payload,
    input  logic [IW-1:0]   i_index,
    output logic [7:0]      o_byte
);

    logic [7:0] w_bytes [NB];

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_byte_slice
            assign w_bytes[g] = i_payload[g*8 +: 8];
        end
    endgenerate

    // Indices past the last byte read as zero.
    always_comb begin
        o_byte = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (i_index == IW'(k)) begin
                o_byte = w_bytes[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/membrane_debug_serializer.sv
`default_nettype none
// ============================================================================
// Module      : membrane_debug_serializer
// Description : Captures a spike/membrane snapshot and streams it as a
//               header-led byte frame over a valid/ready link. Optional
//               trailing XOR checksum under DEBUG_FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module membrane_debug_serializer
    import membrane_debug_serializer_pkg::*;
#(
    parameter int N1 = 8,
    parameter int N2 = 2,
    parameter int PW = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   snapshot,
    input  logic [(N1+N2)*PW-1:0]  membrane_potential_in,
    input  logic [N1-1:0]          spikes_layer1,
    input  logic [N2-1:0]          spikes_out,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [7:0]             drop_count
);

    localparam int c_pbits = (N1 + N2) * PW + N1 + N2;
    localparam int c_nb    = calc_payload_bytes(N1, N2, PW);
    localparam int c_iw    = (c_nb > 1) ? $clog2(c_nb) : 1;
    localparam logic [c_iw-1:0] c_last_index = c_iw'(c_nb - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_nb*8-1:0]   r_payload;
    logic [c_nb*8-1:0]   w_snapshot_bits;
    logic [c_iw-1:0]     r_index;
    logic [7:0]          r_drop_count;
    logic [7:0]          w_payload_byte;
    logic                w_request;
    logic                w_capture;
    logic                w_drop;
    logic                w_xfer;
    logic                w_last_byte;

    assign w_request   = snapshot & enable;
    assign w_capture   = w_request && (r_state == ST_IDLE);
    assign w_drop      = w_request && (r_state != ST_IDLE);
    assign tx_valid    = (r_state != ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign w_xfer      = tx_valid & tx_ready;
    assign w_last_byte = (r_index == c_last_index);
    assign drop_count  = r_drop_count;

    always_comb begin
        w_snapshot_bits = '0;
        w_snapshot_bits[c_pbits-1:0] = {spikes_out, spikes_layer1, membrane_potential_in};
    end

    debug_byte_mux #(
        .NB (c_nb),
        .IW (c_iw)
    ) u_byte_mux (
        .i_payload (r_payload),
        .i_index   (r_index),
        .o_byte    (w_payload_byte)
    );

`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [7:0] r_checksum;

    // Seeded with the header at capture, folded in as each payload byte leaves.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_checksum <= 8'h00;
        end else if (w_capture) begin
            r_checksum <= c_frame_header;
        end else if (w_xfer && (r_state == ST_PAYLOAD)) begin
            r_checksum <= r_checksum ^ w_payload_byte;
        end
    end
`endif

    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            ST_HEADER:   tx_data = c_frame_header;
            ST_PAYLOAD:  tx_data = w_payload_byte;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            ST_CHECKSUM: tx_data = r_checksum;
`endif
            default:     tx_data = 8'h00;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer && w_last_byte) begin
`ifdef DEBUG_FRAME_CHECKSUM_EN
                    w_state_next = ST_CHECKSUM;
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
`ifdef DEBUG_FRAME_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (w_xfer) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload is written only at capture, so a dropped snapshot cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_payload    <= '0;
            r_index      <= '0;
            r_drop_count <= 8'h00;
        end else begin
            if (w_capture) begin
                r_payload <= w_snapshot_bits;
                r_index   <= '0;
            end else if (w_xfer && (r_state == ST_PAYLOAD)) begin
                r_index <= w_last_byte ? '0 : r_index + c_iw'(1);
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_membrane_debug_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_membrane_debug_serializer
// Description : Self-checking bench; expected frame bytes are queued at each
//               snapshot and compared as the serializer hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membrane_debug_serializer;

    localparam int NB = 9;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = NB + 2;
`else
    localparam int FRAME_LEN = NB + 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        snapshot;
    logic [59:0] membrane_potential_in;
    logic [7:0]  spikes_layer1;
    logic [1:0]  spikes_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    membrane_debug_serializer #(
        .N1 (8),
        .N2 (2),
        .PW (6)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .snapshot              (snapshot),
        .membrane_potential_in (membrane_potential_in),
        .spikes_layer1         (spikes_layer1),
        .spikes_out            (spikes_out),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .busy                  (busy),
        .drop_count            (drop_count)
    );

    typedef struct {
        logic [59:0] mp;
        logic [7:0]  s1;
        logic [1:0]  s2;
        logic [71:0] payload;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input vec_t v);
        logic [7:0] chk;
        chk = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(v.payload[k*8 +: 8]);
            chk = chk ^ v.payload[k*8 +: 8];
        end
`ifdef DEBUG_FRAME_CHECKSUM_EN
        exp_q.push_back(chk);
`else
        if (chk == 8'h00) chk = 8'h00;
`endif
    endtask

    // Output monitor, called once per cycle on the falling edge.
    task automatic sample();
        logic [7:0] e;
        if (!reset) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", 72'(tx_valid), 72'(1));
                check("stall_data_held", 72'(tx_data), 72'(held));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h, expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_byte", 72'(tx_data), 72'(e));
                end
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        membrane_potential_in = r[59:0];
        spikes_layer1 = 8'($urandom());
        spikes_out    = 2'($urandom());
    endtask

    task automatic capture(input int i);
        membrane_potential_in = vecs[i].mp;
        spikes_layer1 = vecs[i].s1;
        spikes_out    = vecs[i].s2;
        enable   = 1'b1;
        snapshot = 1'b1;
        push_frame(vecs[i]);
        tick();
        snapshot = 1'b0;
        scramble();
        check("latency_valid", 72'(tx_valid), 72'(1));
        check("header_byte", 72'(tx_data), 72'hA5);
    endtask

    task automatic drain(input bit stall_mode, input int exp_cycles);
        int         cnt;
        logic [3:0] pat;
        pat = 4'b1001;
        cnt = 0;
        while (busy && cnt < 200) begin
            if (stall_mode) tx_ready = pat[cnt % 4];
            cnt++;
            tick();
        end
        tx_ready = 1'b1;
        if (exp_cycles > 0) check("busy_cycles", 72'(cnt), 72'(exp_cycles));
        else check("frame_ended", 72'(busy), 72'(0));
        check("queue_empty", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        vecs[0] = '{mp: 60'h0123456789ABCDE, s1: 8'h5A, s2: 2'b11, payload: 72'h35_A0_12_34_56_78_9A_BC_DE};
        vecs[1] = '{mp: 60'h0,               s1: 8'h00, s2: 2'b00, payload: 72'h0};
        vecs[2] = '{mp: 60'hFFFFFFFFFFFFFFF, s1: 8'hFF, s2: 2'b11, payload: 72'h3F_FF_FF_FF_FF_FF_FF_FF_FF};
        vecs[3] = '{mp: 60'h0,               s1: 8'h00, s2: 2'b10, payload: 72'h20_00_00_00_00_00_00_00_00};
        vecs[4] = '{mp: 60'h800000000000001, s1: 8'h01, s2: 2'b01, payload: 72'h10_18_00_00_00_00_00_00_01};

        reset = 1'b0;
        enable = 1'b0;
        snapshot = 1'b0;
        tx_ready = 1'b1;
        membrane_potential_in = '0;
        spikes_layer1 = '0;
        spikes_out = '0;
        tick();
        tick();
        check("rst_tx_valid", 72'(tx_valid), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_tx_data", 72'(tx_data), 72'(0));
        check("rst_drop_count", 72'(drop_count), 72'(0));
        reset = 1'b1;
        tick();

        // Table-driven frames with tx_ready held high.
        for (int i = 0; i < 5; i++) begin
            capture(i);
            drain(1'b0, FRAME_LEN);
            tick();
        end

        // Backpressure pattern 1-0-0-1.
        capture(0);
        drain(1'b1, 0);
        tick();

        // Three drops mid-frame plus one on the final transfer edge.
        tx_ready = 1'b1;
        capture(1);
        enable = 1'b1;
        for (int j = 0; j < 3; j++) begin
            snapshot = 1'b1;
            tick();
        end
        snapshot = 1'b0;
        for (int j = 4; j < FRAME_LEN; j++) tick();
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
        check("drop_last_busy", 72'(busy), 72'(0));
        check("drop_last_valid", 72'(tx_valid), 72'(0));
        check("drop_count_4", 72'(drop_count), 72'(4));
        tick();
        check("no_capture_on_last", 72'(busy), 72'(0));
        check("drop_queue_empty", 72'(exp_q.size()), 72'(0));

        // Disabled snapshot in IDLE.
        enable = 1'b0;
        snapshot = 1'b1;
        tick();
        tick();
        snapshot = 1'b0;
        check("disabled_busy", 72'(busy), 72'(0));
        check("disabled_valid", 72'(tx_valid), 72'(0));
        check("disabled_drop_count", 72'(drop_count), 72'(4));

        // Reset while payload byte 4 is presented.
        capture(2);
        for (int j = 0; j < 5; j++) tick();
        reset = 1'b0;
        snapshot = 1'b1;
        tick();
        reset = 1'b1;
        snapshot = 1'b0;
        check("abort_valid", 72'(tx_valid), 72'(0));
        check("abort_busy", 72'(busy), 72'(0));
        check("abort_drop_count", 72'(drop_count), 72'(0));
        check("abort_tx_data", 72'(tx_data), 72'(0));
        tick();
        check("abort_idle", 72'(busy), 72'(0));
        capture(0);
        drain(1'b0, FRAME_LEN);
        tick();

        // Drop counter saturation while stalled.
        tx_ready = 1'b0;
        capture(4);
        snapshot = 1'b1;
        for (int j = 0; j < 300; j++) tick();
        snapshot = 1'b0;
        check("drop_saturate", 72'(drop_count), 72'(255));
        tx_ready = 1'b1;
        drain(1'b0, FRAME_LEN);
        check("drop_saturate_hold", 72'(drop_count), 72'(255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
